// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: RAW/WAW issue-stall generation from a per-register
// countdown scoreboard, plus nearest-stage operand forwarding for EX.
// Optional feature macro: FWD_SB_STALL_CNT_EN adds a saturating count of
// stall cycles on stall_cnt; without it stall_cnt is tied to zero.
module fwd_scoreboard #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int MAX_LAT = 4,
  localparam int LW     = $clog2(MAX_LAT + 1),
  localparam int SELW   = $clog2(NUM_FWD + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  output logic                      stall,
  input  logic                      issue_we,
  input  logic [4:0]                issue_rd,
  input  logic [LW-1:0]             issue_lat,
  input  logic [NUM_SRC*5-1:0]      issue_rs,
  input  logic                      flush,
  input  logic [NUM_SRC*5-1:0]      ex_rs,
  input  logic [NUM_SRC*XLEN-1:0]   ex_rf_data,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD*5-1:0]      fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel,
  output logic [NUM_SRC*XLEN-1:0]   ex_op_data,
  output logic [31:0]               stall_cnt
);

  // Countdown value per architectural register; entry 0 is constant zero.
  logic [31:0][LW-1:0] cnt_view;
  logic [LW-1:0]       lat_sat;
  logic                raw_hit;
  logic                waw_hit;
  logic                load_en;

  // Latencies beyond the deepest producer are treated as the deepest producer.
  always_comb begin
    lat_sat = (issue_lat > LW'(MAX_LAT)) ? LW'(MAX_LAT) : issue_lat;
  end

  assign cnt_view[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_cnt
      logic [LW-1:0] cnt_q;
      logic [LW-1:0] cnt_d;

      // Count down towards zero; a new producer for this register overrides the decrement.
      always_comb begin
        cnt_d = (cnt_q != '0) ? cnt_q - LW'(1) : cnt_q;
        if (load_en && (issue_rd == 5'(gi))) begin
          cnt_d = lat_sat;
        end
      end

      // Scoreboard entry; reset forgets every in-flight producer at once.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cnt_view[gi] = cnt_q;
    end
  endgenerate

  // Stall when a source is not yet forwardable by the time the consumer reaches
  // EX (cnt > 1), or when this write would retire before an older one (WAW).
  always_comb begin
    raw_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if ((issue_rs[i*5 +: 5] != 5'd0) && (cnt_view[issue_rs[i*5 +: 5]] > LW'(1))) begin
        raw_hit = 1'b1;
      end
    end
    waw_hit     = issue_we && (issue_rd != 5'd0) && (cnt_view[issue_rd] > lat_sat);
    stall       = issue_valid && !flush && (raw_hit || waw_hit);
    issue_ready = !stall;
    load_en     = issue_valid && !stall && !flush && issue_we && (issue_rd != 5'd0);
  end

  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [4:0]      rs;
      logic [SELW-1:0] sel;
      logic [XLEN-1:0] data;

      assign rs = ex_rs[gi*5 +: 5];

      // Scan from the farthest stage inwards so the nearest match is the one left standing.
      always_comb begin
        sel  = '0;
        data = ex_rf_data[gi*XLEN +: XLEN];
        if (rs == 5'd0) begin
          data = '0;
        end else begin
          for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_valid[k] && (fwd_rd[k*5 +: 5] == rs)) begin
              sel  = SELW'(k + 1);
              data = fwd_data[k*XLEN +: XLEN];
            end
          end
        end
      end

      assign fwd_sel[gi*SELW +: SELW]    = sel;
      assign ex_op_data[gi*XLEN +: XLEN] = data;
    end
  endgenerate

`ifdef FWD_SB_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Count stalled cycles, holding at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

`ifndef SYNTHESIS
  // A producer that is forwardable "now" has no meaning; latency zero is illegal.
  lat_nonzero_a: assert property (@(posedge clk) disable iff (rst)
    (issue_valid && !flush && issue_we) |-> (issue_lat != '0));
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed scenarios plus randomized traffic, checked each
// cycle against a register-array model of pending producer latencies.
module tb_fwd_scoreboard;
  localparam int MAX_LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_we, flush;
  logic        issue_ready, stall;
  logic [4:0]  issue_rd;
  logic [2:0]  issue_lat;
  logic [9:0]  issue_rs, ex_rs, fwd_rd;
  logic [63:0] ex_rf_data, fwd_data, ex_op_data;
  logic [1:0]  fwd_valid;
  logic [3:0]  fwd_sel;
  logic [31:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 0;

  // Model: remaining cycles until each register's pending result is forwardable.
  int          m_cnt [32];
  logic [31:0] m_scnt;

  fwd_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .stall(stall), .issue_we(issue_we), .issue_rd(issue_rd), .issue_lat(issue_lat),
    .issue_rs(issue_rs), .flush(flush), .ex_rs(ex_rs), .ex_rf_data(ex_rf_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd_sel(fwd_sel),
    .ex_op_data(ex_op_data), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_lat(input logic [2:0] l);
    return (int'(l) > MAX_LAT) ? MAX_LAT : int'(l);
  endfunction

  // A consumer may issue only if each source will be forwardable in EX (<= 1 cycle left),
  // and a writer may not finish ahead of an older write to the same register.
  function automatic bit exp_stall();
    if (!issue_valid || flush) return 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (issue_rs[i*5 +: 5] != 5'd0 && m_cnt[issue_rs[i*5 +: 5]] > 1) return 1'b1;
    end
    if (issue_we && issue_rd != 5'd0 && m_cnt[issue_rd] > sat_lat(issue_lat)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    foreach (m_cnt[r]) m_cnt[r] = 0;
    m_scnt = 32'd0;
  endtask

  task automatic model_update();
    bit s;
    s = exp_stall();
    for (int r = 0; r < 32; r++) if (m_cnt[r] > 0) m_cnt[r]--;
    if (issue_valid && !s && !flush && issue_we && issue_rd != 5'd0) m_cnt[issue_rd] = sat_lat(issue_lat);
    if (s && m_scnt != 32'hFFFF_FFFF) m_scnt++;
  endtask

  // Advance one clock, updating the model with the inputs seen at the edge.
  task automatic cyc();
    @(posedge clk);
    if (!rst) model_update();
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_we = 0; flush = 0; issue_rd = 0; issue_lat = 3'd1; issue_rs = 0;
  endtask

  task automatic issue(input logic we, input logic [4:0] rd, input logic [2:0] lat,
                       input logic [4:0] rs0, input logic [4:0] rs1);
    issue_valid = 1; flush = 0; issue_we = we; issue_rd = rd; issue_lat = lat; issue_rs = {rs1, rs0};
  endtask

  task automatic async_reset();
    rst = 1; model_reset(); #2; rst = 0;
  endtask

  // Count stall cycles of the currently presented issue, bounded.
  task automatic count_stalls(output int n);
    n = 0;
    for (int t = 0; t < 10; t++) begin
      settle();
      if (!stall) break;
      n++;
      cyc();
    end
  endtask

  // Single compare process: every output against the model, every negative edge.
  always @(negedge clk) begin
    if (check_en) begin
      logic [1:0]  esel;
      logic [31:0] edata;
      chk("stall", 32'(stall), 32'(exp_stall()));
      chk("issue_ready", 32'(issue_ready), 32'(!exp_stall()));
      for (int i = 0; i < 2; i++) begin
        esel  = 2'd0;
        edata = ex_rf_data[i*32 +: 32];
        if (ex_rs[i*5 +: 5] == 5'd0) edata = 32'd0;
        else begin
          for (int k = 0; k < 2; k++) begin
            if (esel == 2'd0 && fwd_valid[k] && fwd_rd[k*5 +: 5] == ex_rs[i*5 +: 5]) begin
              esel  = 2'(k + 1);
              edata = fwd_data[k*32 +: 32];
            end
          end
        end
        chk("fwd_sel", 32'(fwd_sel[i*2 +: 2]), 32'(esel));
        chk("ex_op_data", ex_op_data[i*32 +: 32], edata);
      end
`ifdef FWD_SB_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, m_scnt);
`else
      chk("stall_cnt", stall_cnt, 32'd0);
`endif
    end
  end

  initial begin
    int n;
    rst = 1; idle();
    ex_rs = 0; ex_rf_data = 0; fwd_valid = 0; fwd_rd = 0; fwd_data = 0;
    model_reset();
    repeat (2) cyc();
    rst = 0;
    check_en = 1;

    settle();
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_ready", 32'(issue_ready), 32'd1);
    chk("reset_stall_cnt", stall_cnt, 32'd0);
    $display("reset state checked");

    // Load-use: one bubble, then forwarded from stage 0 in EX.
    issue(1, 5'd5, 3'd2, 5'd0, 5'd0);
    settle(); chk("lu_producer", 32'(stall), 32'd0);
    cyc();
    issue(0, 5'd0, 3'd1, 5'd5, 5'd0);
    settle(); chk("lu_stall", 32'(stall), 32'd1); chk("lu_ready", 32'(issue_ready), 32'd0);
    cyc();
    settle(); chk("lu_accept", 32'(stall), 32'd0);
    ex_rs = {5'd0, 5'd5}; fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd5};
    fwd_data = {32'h0, 32'hDEAD_BEEF}; ex_rf_data = {32'h0, 32'h1111_1111};
    settle(); chk("lu_sel", 32'(fwd_sel[1:0]), 32'd1); chk("lu_data", ex_op_data[31:0], 32'hDEAD_BEEF);
    $display("load-use scenario done");
    cyc(); idle();

    // Multi-cycle producer: three bubbles.
    async_reset();
    issue(1, 5'd7, 3'd4, 5'd0, 5'd0);
    cyc();
    issue(0, 5'd0, 3'd1, 5'd0, 5'd7);
    count_stalls(n);
    chk("mc_bubbles", 32'(n), 32'd3);
`ifdef FWD_SB_STALL_CNT_EN
    chk("mc_stall_cnt", stall_cnt, 32'd3);
`else
    chk("mc_stall_cnt", stall_cnt, 32'd0);
`endif
    $display("multi-cycle scenario done: %0d bubbles", n);
    cyc(); idle();

    // Forwarding priority: nearest stage wins; x0 never forwards.
    ex_rs = {5'd3, 5'd0}; fwd_valid = 2'b11; fwd_rd = {5'd3, 5'd3};
    fwd_data = {32'hBBBB_0001, 32'hAAAA_0000}; ex_rf_data = {32'hCCCC_0002, 32'hCCCC_0003};
    settle();
    chk("prio_sel", 32'(fwd_sel[3:2]), 32'd1); chk("prio_data", ex_op_data[63:32], 32'hAAAA_0000);
    chk("x0_sel", 32'(fwd_sel[1:0]), 32'd0); chk("x0_data", ex_op_data[31:0], 32'd0);
    fwd_valid = 2'b10; settle();
    chk("far_sel", 32'(fwd_sel[3:2]), 32'd2); chk("far_data", ex_op_data[63:32], 32'hBBBB_0001);
    fwd_valid = 2'b00; settle();
    chk("rf_data", ex_op_data[63:32], 32'hCCCC_0002);
    fwd_valid = 2'b11; fwd_rd = {5'd0, 5'd0}; ex_rs = 0; settle();
    chk("x0_fwd_sel", 32'(fwd_sel), 32'd0);
    $display("forwarding priority scenario done");

    // x0 write is never tracked.
    issue(1, 5'd0, 3'd4, 5'd0, 5'd0);
    cyc();
    issue(0, 5'd0, 3'd1, 5'd0, 5'd0);
    settle(); chk("x0_nostall", 32'(stall), 32'd0);
    cyc();

    // WAW: short write behind long write to x9 waits until older one is close enough.
    issue(1, 5'd9, 3'd4, 5'd0, 5'd0);
    cyc();
    issue(1, 5'd9, 3'd1, 5'd0, 5'd0);
    count_stalls(n);
    chk("waw_bubbles", 32'(n), 32'd3);
    $display("x0 / WAW scenario done: %0d bubbles", n);
    cyc(); idle();
    repeat (5) cyc();

    // Flush: no stall, no load, pending entries keep counting.
    issue(1, 5'd4, 3'd4, 5'd0, 5'd0);
    cyc();
    issue(1, 5'd6, 3'd4, 5'd4, 5'd0); flush = 1;
    settle(); chk("flush_nostall", 32'(stall), 32'd0);
    cyc();
    issue(0, 5'd0, 3'd1, 5'd4, 5'd0);
    settle(); chk("flush_pending", 32'(stall), 32'd1);
    issue(0, 5'd0, 3'd1, 5'd6, 5'd0);
    settle(); chk("flush_noload", 32'(stall), 32'd0);
    $display("flush scenario done");
    idle(); repeat (5) cyc();

    // Async reset mid-countdown forgets the pending producer at once.
    issue(1, 5'd4, 3'd4, 5'd0, 5'd0);
    cyc(); idle(); cyc();
    issue(0, 5'd0, 3'd1, 5'd4, 5'd0);
    settle(); chk("pre_rst_stall", 32'(stall), 32'd1);
    rst = 1; model_reset();
    settle(); chk("rst_nostall", 32'(stall), 32'd0); chk("rst_stall_cnt", stall_cnt, 32'd0);
    rst = 0;
    settle(); chk("post_rst_nostall", 32'(stall), 32'd0);
    $display("async reset scenario done");
    cyc();

    // Over-range latency behaves as MAX_LAT.
    issue(1, 5'd10, 3'd7, 5'd0, 5'd0);
    cyc();
    issue(0, 5'd0, 3'd1, 5'd10, 5'd0);
    count_stalls(n);
    chk("sat_bubbles", 32'(n), 32'd3);
    $display("latency saturation scenario done: %0d bubbles", n);
    cyc(); idle();

    // Randomized traffic on a small register window so hazards are frequent.
    for (int t = 0; t < 3000; t++) begin
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_we    = $urandom_range(0, 1) == 1;
      issue_rd    = 5'($urandom_range(0, 7));
      issue_lat   = 3'($urandom_range(1, 7));
      issue_rs    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      flush       = ($urandom_range(0, 9) == 0);
      ex_rs       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fwd_valid   = 2'($urandom_range(0, 3));
      fwd_rd      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fwd_data    = {$urandom, $urandom};
      ex_rf_data  = {$urandom, $urandom};
      if ($urandom_range(0, 299) == 0) async_reset();
      cyc();
    end
    $display("random phase done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
